// File: rtl/acumulador_productos_if.sv
// Handshake bundle for the multiply-accumulate stage: operand input side and result output side.
interface acumulador_productos_if #(
    parameter int unsigned W = 24
);
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     Dato_A;
    logic [W-1:0]     Dato_B;
    logic             out_valid;
    logic             out_ready;
    logic [2*W-1:0]   Datos_Sum;
    logic             sat;

    modport master (
        output in_valid, Dato_A, Dato_B, out_ready,
        input  in_ready, out_valid, Datos_Sum, sat
    );

    modport slave (
        input  in_valid, Dato_A, Dato_B, out_ready,
        output in_ready, out_valid, Datos_Sum, sat
    );
endinterface

// File: rtl/acumulador_productos.sv
// Signed multiply-accumulate: TERMS products of W-bit operands summed with saturation into 2W bits.
// Two-stage pipe (product register, accumulator) with valid/ready on both sides.
module acumulador_productos #(
    parameter int unsigned W     = 24,
    parameter int unsigned TERMS = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clr,
    acumulador_productos_if.slave bus
);
    localparam int unsigned W2   = 2 * W;
    localparam int unsigned CntW = (TERMS > 2) ? $clog2(TERMS) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(TERMS - 1);
    localparam logic [W2-1:0]   SatPos  = {1'b0, {(W2 - 1){1'b1}}};
    localparam logic [W2-1:0]   SatNeg  = {1'b1, {(W2 - 1){1'b0}}};

    typedef enum logic [1:0] {StAcum, StDrenar, StSalida} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            drain_q, drain_d;
    logic [W2-1:0]   p_q, p_d;
    logic [W2-1:0]   acc_q, acc_d;
    logic            sat_int_q, sat_int_d;
    logic [W2-1:0]   sum_q, sum_d;
    logic            sat_q, sat_d;

    logic            accept;
    logic [W2-1:0]   a_ext, b_ext, prod;
    logic [W2:0]     sum_ext;
    logic            ovf;
    logic [W2-1:0]   acc_sat;

    // Sign-extending both operands to 2W makes the low 2W bits the exact signed product.
    assign a_ext = {{W{bus.Dato_A[W-1]}}, bus.Dato_A};
    assign b_ext = {{W{bus.Dato_B[W-1]}}, bus.Dato_B};
    assign prod  = a_ext * b_ext;

    assign sum_ext = {acc_q[W2-1], acc_q} + {p_q[W2-1], p_q};
    assign ovf     = sum_ext[W2] ^ sum_ext[W2-1];
    assign acc_sat = ovf ? (sum_ext[W2] ? SatNeg : SatPos) : sum_ext[W2-1:0];

    assign accept = bus.in_valid && (state_q == StAcum) && !clr;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        drain_d   = drain_q;
        // P is zero on idle cycles, so the accumulator can add it unconditionally.
        p_d       = accept ? prod : '0;
        acc_d     = acc_sat;
        sat_int_d = sat_int_q | ovf;
        sum_d     = sum_q;
        sat_d     = sat_q;

        unique case (state_q)
            StAcum: begin
                if (accept) begin
                    if (cnt_q == CntLast) begin
                        state_d = StDrenar;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            StDrenar: begin
                if (drain_q) begin
                    state_d = StSalida;
                    drain_d = 1'b0;
                    sum_d   = acc_q;
                    sat_d   = sat_int_q;
                end else begin
                    drain_d = 1'b1;
                end
            end
            StSalida: begin
                if (bus.out_ready) begin
                    state_d   = StAcum;
                    acc_d     = '0;
                    cnt_d     = '0;
                    sat_int_d = 1'b0;
                end
            end
            default: begin
                state_d = StAcum;
            end
        endcase

        if (clr) begin
            state_d   = StAcum;
            cnt_d     = '0;
            drain_d   = 1'b0;
            p_d       = '0;
            acc_d     = '0;
            sat_int_d = 1'b0;
            sum_d     = sum_q;
            sat_d     = sat_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StAcum;
            cnt_q     <= '0;
            drain_q   <= 1'b0;
            p_q       <= '0;
            acc_q     <= '0;
            sat_int_q <= 1'b0;
            sum_q     <= '0;
            sat_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            drain_q   <= drain_d;
            p_q       <= p_d;
            acc_q     <= acc_d;
            sat_int_q <= sat_int_d;
            sum_q     <= sum_d;
            sat_q     <= sat_d;
        end
    end

    assign bus.in_ready  = (state_q == StAcum);
    assign bus.out_valid = (state_q == StSalida);
    assign bus.Datos_Sum = sum_q;
    assign bus.sat       = sat_q;
endmodule

// File: tb/tb_acumulador_productos.sv
// Bench for acumulador_productos: directed cases plus random batches against a saturating-sum
// reference model, with results checked through a scoreboard queue.
module tb_acumulador_productos;
    localparam int unsigned W     = 24;
    localparam int unsigned TERMS = 8;
    localparam longint      SMAX  = (64'sd1 <<< 47) - 1;
    localparam longint      SMIN  = -(64'sd1 <<< 47);

    logic clk = 1'b0;
    logic reset;
    logic clr;
    logic mode_rand = 1'b0;
    logic ready_req = 1'b1;
    logic rnd_ready = 1'b1;

    int n_checks = 0;
    int n_fail   = 0;

    longint      pend[$];
    logic [47:0] exp_sum[$];
    logic        exp_sat[$];

    acumulador_productos_if #(.W(W)) bus ();

    acumulador_productos #(.W(W), .TERMS(TERMS)) dut (
        .clk   (clk),
        .reset (reset),
        .clr   (clr),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    assign bus.out_ready = mode_rand ? rnd_ready : ready_req;

    always @(posedge clk) begin
        #1;
        rnd_ready = 1'($urandom_range(0, 1));
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: exact products summed one at a time, clamping to the 48-bit signed range.
    task automatic model_push(input logic [W-1:0] a, input logic [W-1:0] b);
        longint sa, sb, acc;
        bit     s;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        pend.push_back(sa * sb);
        if (pend.size() == TERMS) begin
            acc = 0;
            s   = 1'b0;
            foreach (pend[i]) begin
                acc = acc + pend[i];
                if (acc > SMAX) begin acc = SMAX; s = 1'b1; end
                else if (acc < SMIN) begin acc = SMIN; s = 1'b1; end
            end
            exp_sum.push_back(acc[47:0]);
            exp_sat.push_back(s);
            pend.delete();
        end
    endtask

    always @(negedge clk) begin
        if (!reset && bus.out_valid && bus.out_ready) begin
            if (exp_sum.size() == 0) begin
                check("unexpected_output", 64'(bus.Datos_Sum), 64'hDEAD);
            end else begin
                check("Datos_Sum", 64'(bus.Datos_Sum), 64'(exp_sum.pop_front()));
                check("sat", 64'(bus.sat), 64'(exp_sat.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called at posedge+1; returns at posedge+1 right after the accepting edge.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
        bit ok;
        ok = 1'b0;
        bus.Dato_A   = a;
        bus.Dato_B   = b;
        bus.in_valid = 1'b1;
        for (int g = 0; g < 300 && !ok; g++) begin
            @(negedge clk);
            if (bus.in_ready) ok = 1'b1;
            tick();
        end
        bus.in_valid = 1'b0;
        if (ok) model_push(a, b);
        else check("accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic batch(input logic [W-1:0] a, input logic [W-1:0] b);
        for (int i = 0; i < TERMS; i++) send(a, b);
    endtask

    function automatic logic [W-1:0] rnd_op();
        case ($urandom_range(0, 3))
            0:       return 24'h800000;
            1:       return 24'h7FFFFF;
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [47:0] s0;
        logic        t0;
        bit          seen;

        reset        = 1'b1;
        clr          = 1'b0;
        bus.in_valid = 1'b0;
        bus.Dato_A   = '0;
        bus.Dato_B   = '0;
        #12;
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_sum", 64'(bus.Datos_Sum), 64'd0);
        check("rst_sat", 64'(bus.sat), 64'd0);
        tick();
        reset = 1'b0;
        tick();
        tick();
        check("idle_in_ready", 64'(bus.in_ready), 64'd1);
        check("idle_out_valid", 64'(bus.out_valid), 64'd0);

        // 2*3 x 8 = 48, with latency and in_ready timing checks
        batch(24'd2, 24'd3);
        @(negedge clk);
        check("lat_e0_valid", 64'(bus.out_valid), 64'd0);
        check("lat_e0_ready", 64'(bus.in_ready), 64'd0);
        tick();
        @(negedge clk);
        check("lat_e1_valid", 64'(bus.out_valid), 64'd0);
        check("lat_e1_ready", 64'(bus.in_ready), 64'd0);
        tick();
        @(negedge clk);
        check("lat_e2_valid", 64'(bus.out_valid), 64'd1);
        check("lat_e2_sum", 64'(bus.Datos_Sum), 64'd48);
        tick();

        batch(24'hFFFFFF, 24'h000001);
        batch(24'h800000, 24'h800000);
        batch(24'd5, 24'hFFFFF9);

        // Stall with result pending
        for (int g = 0; g < 50 && exp_sum.size() != 0; g++) tick();
        ready_req = 1'b0;
        batch(24'd1, 24'd1);
        seen = 1'b0;
        for (int g = 0; g < 10 && !seen; g++) begin
            @(negedge clk);
            if (bus.out_valid) seen = 1'b1;
            else tick();
        end
        check("stall_valid_seen", 64'(seen), 64'd1);
        s0 = bus.Datos_Sum;
        t0 = bus.sat;
        check("stall_sum_value", 64'(s0), 64'd8);
        for (int i = 0; i < 5; i++) begin
            tick();
            bus.in_valid = 1'(i);
            bus.Dato_A   = W'($urandom);
            bus.Dato_B   = W'($urandom);
            @(negedge clk);
            check("stall_sum_stable", 64'(bus.Datos_Sum), 64'(s0));
            check("stall_sat_stable", 64'(bus.sat), 64'(t0));
            check("stall_in_ready", 64'(bus.in_ready), 64'd0);
            check("stall_out_valid", 64'(bus.out_valid), 64'd1);
        end
        tick();
        bus.in_valid = 1'b0;
        ready_req    = 1'b1;
        tick();
        @(negedge clk);
        check("post_hs_valid", 64'(bus.out_valid), 64'd0);
        check("post_hs_ready", 64'(bus.in_ready), 64'd1);
        tick();

        // Async reset after 3 accepts
        for (int i = 0; i < 3; i++) send(24'd7, 24'd9);
        #2;
        reset = 1'b1;
        #1;
        check("arst_in_ready", 64'(bus.in_ready), 64'd1);
        check("arst_out_valid", 64'(bus.out_valid), 64'd0);
        check("arst_sum", 64'(bus.Datos_Sum), 64'd0);
        check("arst_sat", 64'(bus.sat), 64'd0);
        pend.delete();
        tick();
        reset = 1'b0;
        tick();
        batch(24'd1, 24'd1);

        // clr after 5 accepts, with a pair presented alongside clr
        for (int i = 0; i < 5; i++) send(24'd11, 24'd13);
        clr          = 1'b1;
        bus.in_valid = 1'b1;
        bus.Dato_A   = 24'd5;
        bus.Dato_B   = 24'd5;
        tick();
        clr          = 1'b0;
        bus.in_valid = 1'b0;
        pend.delete();
        @(negedge clk);
        check("clr_in_ready", 64'(bus.in_ready), 64'd1);
        check("clr_out_valid", 64'(bus.out_valid), 64'd0);
        tick();
        batch(24'd1, 24'd1);

        // Random batches with gaps and a randomly stalling consumer
        mode_rand = 1'b1;
        for (int n = 0; n < 20; n++) begin
            for (int i = 0; i < TERMS; i++) begin
                int gap;
                gap = $urandom_range(0, 2);
                for (int k = 0; k < gap; k++) begin
                    bus.Dato_A = W'($urandom);
                    bus.Dato_B = W'($urandom);
                    tick();
                end
                send(rnd_op(), rnd_op());
            end
        end

        mode_rand = 1'b0;
        ready_req = 1'b1;
        for (int g = 0; g < 100 && exp_sum.size() != 0; g++) tick();
        check("scoreboard_drained", 64'(exp_sum.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
